// File: rtl/mmd_pkg.sv
// Shared state encoding and default sizing for the byte sequencer that feeds
// the 16-to-1 byte multiplexer stage.
package mmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } mmd_state_t;

    localparam int MMD_NUM_BYTES = 16;
    localparam int MMD_BYTE_W    = 8;
    localparam int MMD_SEL_W     = 4;

endpackage

// File: rtl/mmd_byte_sequencer_if.sv
// Byte-in / select-out stream bundle between the sequencer (slave) and the
// block that feeds bytes and consumes select/byte pairs (master).
interface mmd_byte_sequencer_if
    import mmd_pkg::*;
#(
    parameter int NUM_BYTES = MMD_NUM_BYTES,
    parameter int BYTE_W    = MMD_BYTE_W,
    parameter int SEL_W     = MMD_SEL_W
);
    logic                        start;
    logic                        in_valid;
    logic                        in_ready;
    logic [BYTE_W-1:0]           in_data;
    logic [NUM_BYTES*BYTE_W-1:0] data_inputs;
    logic [SEL_W-1:0]            select;
    logic                        sel_valid;
    logic                        sel_ready;
    logic                        sel_last;
    logic                        done;

    modport master (
        output start, in_valid, in_data, sel_ready,
        input  in_ready, data_inputs, select, sel_valid, sel_last, done
    );

    modport slave (
        input  start, in_valid, in_data, sel_ready,
        output in_ready, data_inputs, select, sel_valid, sel_last, done
    );

endinterface

// File: rtl/mmd_mod_counter.sv
// Wrapping SEL_W-bit index counter with clear, enable and direction control.
// Clear loads the first value of the chosen direction; tc flags the last one.
module mmd_mod_counter #(
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    output logic [SEL_W-1:0] count,
    output logic             tc
);
    logic [SEL_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= up ? '0 : '1;
        end else if (en) begin
            count_reg <= up ? (count_reg + SEL_W'(1)) : (count_reg - SEL_W'(1));
        end
    end

    assign count = count_reg;
    assign tc    = up ? (count_reg == '1) : (count_reg == '0);

endmodule

// File: rtl/mmd_byte_sequencer.sv
// Collects NUM_BYTES bytes into a flat mux buffer, then sweeps the select index
// once with backpressure and pulses done. MMD_REVERSE_SCAN_EN selects a
// descending sweep; loading order is the same in both builds.
module mmd_byte_sequencer
    import mmd_pkg::*;
#(
    parameter int NUM_BYTES = MMD_NUM_BYTES,
    parameter int BYTE_W    = MMD_BYTE_W,
    parameter int SEL_W     = MMD_SEL_W
) (
    input logic                 clk,
    input logic                 rst,
    mmd_byte_sequencer_if.slave bus
);
`ifdef MMD_REVERSE_SCAN_EN
    localparam logic SCAN_UP = 1'b0;
`else
    localparam logic SCAN_UP = 1'b1;
`endif

    mmd_state_t        state_reg;
    logic              in_ready_reg;
    logic              sel_valid_reg;
    logic              done_reg;
    logic [BYTE_W-1:0] lane_reg [NUM_BYTES];

    logic [SEL_W-1:0]  byte_cnt;
    logic [SEL_W-1:0]  scan_cnt;
    logic              byte_tc;
    logic              scan_tc;
    logic              frame_start;
    logic              load_accept;
    logic              scan_take;

    // Handshakes only use registered flags, so no input reaches an output.
    assign frame_start = (state_reg == ST_IDLE) && bus.start;
    assign load_accept = in_ready_reg && bus.in_valid;
    assign scan_take   = sel_valid_reg && bus.sel_ready;

    mmd_mod_counter #(.SEL_W(SEL_W)) u_byte_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (frame_start),
        .en    (load_accept),
        .up    (1'b1),
        .count (byte_cnt),
        .tc    (byte_tc)
    );

    mmd_mod_counter #(.SEL_W(SEL_W)) u_scan_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (frame_start),
        .en    (scan_take),
        .up    (SCAN_UP),
        .count (scan_cnt),
        .tc    (scan_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            in_ready_reg  <= 1'b0;
            sel_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg    <= ST_LOAD;
                        in_ready_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_accept && byte_tc) begin
                        state_reg     <= ST_SCAN;
                        in_ready_reg  <= 1'b0;
                        sel_valid_reg <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_take && scan_tc) begin
                        state_reg     <= ST_DONE;
                        sel_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b0;
                    sel_valid_reg <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    // The buffer is only written during LOAD, so it holds steady through SCAN.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (load_accept && (byte_cnt == SEL_W'(gi))) begin
                    lane_reg[gi] <= bus.in_data;
                end
            end
            assign bus.data_inputs[BYTE_W*gi +: BYTE_W] = lane_reg[gi];
        end
    endgenerate

    assign bus.in_ready  = in_ready_reg;
    assign bus.sel_valid = sel_valid_reg;
    assign bus.select    = sel_valid_reg ? scan_cnt : '0;
    assign bus.sel_last  = sel_valid_reg && scan_tc;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_mmd_byte_sequencer.sv
// Scoreboard bench for mmd_byte_sequencer: expected select/byte pairs are queued
// when a frame is set up and popped on each consumer handshake.
module tb_mmd_byte_sequencer;
    localparam int NB = 16;
    localparam int BW = 8;
    localparam int SW = 4;
`ifdef MMD_REVERSE_SCAN_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [BW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mmd_byte_sequencer_if #(.NUM_BYTES(NB), .BYTE_W(BW), .SEL_W(SW)) bus ();

    mmd_byte_sequencer #(.NUM_BYTES(NB), .BYTE_W(BW), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t             sb_q[$];
    int               checks   = 0;
    int               failures = 0;
    int               done_cnt = 0;
    logic [BW-1:0]    frame_bytes [NB];
    logic [NB*BW-1:0] exp_buf;
    logic [NB*BW-1:0] dut_buf;

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && bus.done) done_cnt++;
    endtask

    task automatic push_expect();
        exp_t e;
        int   idx;
        for (int i = 0; i < NB; i++) exp_buf[i*BW +: BW] = frame_bytes[i];
        for (int i = 0; i < NB; i++) begin
            idx    = REV ? (NB - 1 - i) : i;
            e.sel  = SW'(idx);
            e.data = frame_bytes[idx];
            e.last = (i == NB - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_to_load in_ready=%b expected=1", bus.in_ready);
        end
    endtask

    task automatic send_bytes(input int first, input int last, input bit gaps);
        bit accepted;
        int guard;
        for (int i = first; i <= last; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = frame_bytes[i];
            guard = 0;
            do begin
                accepted = bus.in_ready;
                tick();
                guard++;
            end while (!accepted && guard < 20);
            if (!accepted) begin
                checks++;
                failures++;
                $display("FAIL load_timeout byte=%0d in_ready=%b expected=1", i, bus.in_ready);
            end
            bus.in_valid = 1'b0;
            if (gaps && i != last) begin
                bus.in_data = BW'($urandom);
                tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_scan(input int stall_at, output int cycles);
        exp_t e;
        bit   stalled;
        int   guard;
        cycles  = 0;
        stalled = 1'b0;
        guard   = 0;
        bus.sel_ready = 1'b1;
        while (!bus.done && guard < 100) begin
            if (bus.sel_valid && stall_at >= 0 && !stalled && int'(bus.select) == stall_at) begin
                stalled = 1'b1;
                bus.sel_ready = 1'b0;
                repeat (3) begin
                    checks++;
                    if (bus.select !== SW'(stall_at) || bus.sel_valid !== 1'b1 || bus.sel_last !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_hold select=%0d valid=%b last=%b expected select=%0d valid=1 last=0",
                                 bus.select, bus.sel_valid, bus.sel_last, stall_at);
                    end
                    cycles++;
                    tick();
                end
                bus.sel_ready = 1'b1;
            end else begin
                if (bus.sel_valid) begin
                    cycles++;
                    checks++;
                    if (bus.data_inputs !== exp_buf) begin
                        failures++;
                        $display("FAIL buf_held data_inputs=%h expected=%h", bus.data_inputs, exp_buf);
                    end
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_extra select=%0d expected no further pair", bus.select);
                    end else begin
                        e = sb_q.pop_front();
                        if (bus.select !== e.sel || bus.data_inputs[int'(bus.select)*BW +: BW] !== e.data
                            || bus.sel_last !== e.last) begin
                            failures++;
                            $display("FAIL sb_pair select=%0d byte=%h last=%b expected select=%0d byte=%h last=%b",
                                     bus.select, bus.data_inputs[int'(bus.select)*BW +: BW], bus.sel_last,
                                     e.sel, e.data, e.last);
                        end
                    end
                end
                tick();
                guard++;
            end
        end
        checks++;
        if (!bus.done || sb_q.size() != 0) begin
            failures++;
            $display("FAIL scan_end done=%b pending=%0d expected done=1 pending=0", bus.done, sb_q.size());
        end
        dut_buf = exp_buf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            bus.start     = 1'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = BW'($urandom);
            bus.sel_ready = 1'($urandom);
            tick();
        end
        checks++;
        if (bus.data_inputs !== '0 || bus.select !== '0 || bus.in_ready !== 1'b0
            || bus.sel_valid !== 1'b0 || bus.sel_last !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state buf=%h sel=%0d rdy=%b vld=%b last=%b done=%b expected all 0",
                     bus.data_inputs, bus.select, bus.in_ready, bus.sel_valid, bus.sel_last, bus.done);
        end
        rst = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.sel_ready = 1'b0;
        dut_buf = '0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.sel_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset rdy=%b vld=%b expected 0 0", bus.in_ready, bus.sel_valid);
        end
    endtask

    task automatic test_full_frame();
        int cyc;
        int d0;
        logic [NB*BW-1:0] golden;
        golden = 128'h1F1E1D1C1B1A19181716151413121110;
        d0 = done_cnt;
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'(8'h10 + i);
        push_expect();
        start_frame();
        send_bytes(0, NB - 1, 1'b0);
        checks++;
        if (bus.sel_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.select !== (REV ? SW'(NB - 1) : SW'(0))) begin
            failures++;
            $display("FAIL scan_latency vld=%b rdy=%b sel=%0d expected vld=1 rdy=0 sel=%0d",
                     bus.sel_valid, bus.in_ready, bus.select, REV ? NB - 1 : 0);
        end
        checks++;
        if (bus.data_inputs !== golden) begin
            failures++;
            $display("FAIL full_buffer data_inputs=%h expected=%h", bus.data_inputs, golden);
        end
        drain_scan(-1, cyc);
        checks++;
        if (cyc != NB || bus.sel_valid !== 1'b0 || bus.select !== '0) begin
            failures++;
            $display("FAIL full_sweep cycles=%0d vld=%b sel=%0d expected cycles=%0d vld=0 sel=0",
                     cyc, bus.sel_valid, bus.select, NB);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL done_pulse done=%b pulses=%0d expected done=0 pulses=%0d", bus.done, done_cnt - d0, 1);
        end
    endtask

    task automatic test_stalls();
        int cyc;
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'($urandom);
        push_expect();
        start_frame();
        send_bytes(0, NB - 1, 1'b1);
        checks++;
        if (bus.data_inputs !== exp_buf) begin
            failures++;
            $display("FAIL stall_pack data_inputs=%h expected=%h", bus.data_inputs, exp_buf);
        end
        drain_scan(5, cyc);
        checks++;
        if (cyc != NB + 3) begin
            failures++;
            $display("FAIL stall_cycles cycles=%0d expected=%0d", cyc, NB + 3);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int cyc;
        int d0;
        logic [NB*BW-1:0] partial;
        d0 = done_cnt;
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'($urandom);
        partial = dut_buf;
        for (int i = 0; i < 4; i++) partial[i*BW +: BW] = frame_bytes[i];
        push_expect();
        start_frame();
        send_bytes(0, 3, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.sel_valid !== 1'b0 || bus.data_inputs !== partial) begin
            failures++;
            $display("FAIL start_in_load rdy=%b vld=%b buf=%h expected rdy=1 vld=0 buf=%h",
                     bus.in_ready, bus.sel_valid, bus.data_inputs, partial);
        end
        send_bytes(4, NB - 1, 1'b0);
        bus.sel_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.sel_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_inputs !== exp_buf
            || bus.select !== (REV ? SW'(NB - 1) : SW'(0))) begin
            failures++;
            $display("FAIL start_in_scan vld=%b rdy=%b sel=%0d buf=%h expected vld=1 rdy=0 sel=%0d buf=%h",
                     bus.sel_valid, bus.in_ready, bus.select, bus.data_inputs, REV ? NB - 1 : 0, exp_buf);
        end
        drain_scan(-1, cyc);
        tick();
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL start_not_queued rdy=%b pulses=%0d expected rdy=0 pulses=1", bus.in_ready, done_cnt - d0);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int d0;
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'($urandom);
        push_expect();
        start_frame();
        send_bytes(0, 6, 1'b0);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.data_inputs !== '0 || bus.in_ready !== 1'b0 || bus.sel_valid !== 1'b0
            || bus.done !== 1'b0 || bus.select !== '0) begin
            failures++;
            $display("FAIL mid_reset buf=%h rdy=%b vld=%b done=%b sel=%0d expected all 0",
                     bus.data_inputs, bus.in_ready, bus.sel_valid, bus.done, bus.select);
        end
        rst = 1'b0;
        sb_q.delete();
        dut_buf = '0;
        d0 = done_cnt;
        repeat (3) tick();
        checks++;
        if (done_cnt != d0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done pulses=%0d rdy=%b expected pulses=0 rdy=0", done_cnt - d0, bus.in_ready);
        end
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'($urandom);
        push_expect();
        start_frame();
        send_bytes(0, NB - 1, 1'b0);
        drain_scan(-1, cyc);
        tick();
        tick();
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL post_reset_frame pulses=%0d expected=1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'($urandom);
        push_expect();
        start_frame();
        send_bytes(0, NB - 1, 1'b0);
        drain_scan(-1, cyc);
        for (int i = 0; i < NB; i++) frame_bytes[i] = BW'(NB - 1 - i) ^ BW'(8'hA5);
        push_expect();
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap1 rdy=%b done=%b expected rdy=0 done=0", bus.in_ready, bus.done);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap2 rdy=%b expected=1", bus.in_ready);
        end
        send_bytes(0, NB - 1, 1'b1);
        drain_scan(-1, cyc);
        tick();
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.sel_ready = 1'b0;
        test_reset();
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
        test_full_frame();
        $display("test_full_frame done checks=%0d failures=%0d", checks, failures);
        test_stalls();
        $display("test_stalls done checks=%0d failures=%0d", checks, failures);
        test_ignored_start();
        $display("test_ignored_start done checks=%0d failures=%0d", checks, failures);
        test_mid_reset();
        $display("test_mid_reset done checks=%0d failures=%0d", checks, failures);
        test_back_to_back();
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmd_byte_sequencer.md
Name: mmd_byte_sequencer

Overview:
- Upstream feeder for the 16-to-1 byte multiplexer stage.
- Collects NUM_BYTES bytes over a valid/ready stream and packs them into a flat buffer, which drives the mux data input.
- Then sweeps the mux select index once, with downstream backpressure, so the consumer sees every byte in order.
- Pulses done when the sweep completes.

Parameters:
- NUM_BYTES, 16, number of bytes per frame; power of two, at least 2.
- BYTE_W, 8, width of one byte lane.
- SEL_W, 4, select width; must equal clog2(NUM_BYTES).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a new frame; honoured only in IDLE.
- in_valid  in  1  input byte valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- in_data  in  BYTE_W  input byte.
- data_inputs  out  NUM_BYTES*BYTE_W  packed buffer; byte k occupies bits [BYTE_W*k+BYTE_W-1 : BYTE_W*k].
- select  out  SEL_W  mux select index.
- sel_valid  out  1  select/byte pair is valid for the consumer.
- sel_ready  in  1  consumer takes the current pair.
- sel_last  out  1  current pair is the final one of the sweep.
- done  out  1  one-cycle pulse after the final pair is taken.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: state IDLE; data_inputs all 0; select 0; in_ready, sel_valid, sel_last and done all 0; byte counter 0.
- States: IDLE, LOAD, SCAN, DONE. All outputs are decoded from registered state and counters; there is no combinational in->out path.
- IDLE:
  - start=1 clears the byte counter and moves to LOAD next cycle.
  - The buffer is not cleared; it is overwritten during LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid && in_ready, in_data is written to lane[cnt] and cnt increments.
  - The accept with cnt==NUM_BYTES-1 moves to SCAN next cycle; cnt wraps to 0.
  - in_valid low stalls with no change.
  - Latency: last accept to first sel_valid is 1 cycle.
- SCAN:
  - in_ready=0; sel_valid=1.
  - select = scan index, starting at 0.
  - sel_valid && sel_ready advances the index by 1.
  - sel_ready low holds select and sel_last stable.
  - sel_last=1 when the index is NUM_BYTES-1.
  - Handshake with sel_last moves to DONE; the index wraps to 0.
  - data_inputs is held constant throughout SCAN.
- DONE:
  - done=1 for exactly one cycle; then IDLE.
  - select returns to 0 and sel_valid to 0.
- start outside IDLE is ignored; no queuing.
- in_data outside LOAD is ignored; the buffer is untouched.
- Reset mid-frame, in any state: all reset values apply on the next edge, the partial frame is discarded, and no done pulse is issued.
- Back-to-back frames: start is sampled in IDLE the cycle after DONE. The minimum gap between done and the next in_ready is 2 cycles.

Optional Feature:
- Macro: MMD_REVERSE_SCAN_EN.
- Defined:
  - The SCAN index starts at NUM_BYTES-1 and decrements.
  - sel_last is asserted at index 0.
  - DONE and IDLE still leave select at 0.
- Undefined: ascending scan as described in Behaviour.
- LOAD packing order is identical in both builds.

Decomposition:
- Package mmd_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, SCAN=2'd2, DONE=2'd3);
  - default constants MMD_NUM_BYTES=16, MMD_BYTE_W=8, MMD_SEL_W=4.
- One natural sub-module, mmd_mod_counter:
  - SEL_W-bit counter with clear, enable and up/down control;
  - terminal-count flag output;
  - instantiated twice, for the byte index and the scan index.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> data_inputs=0, select=0, in_ready=0, sel_valid=0, done=0.
- Full frame:
  - Stimulus: start, then bytes 0x10..0x1F back-to-back; sel_ready=1 throughout.
  - Response: data_inputs=0x1F1E1D1C1B1A19181716151413121110; select steps 0..15 on 16 consecutive cycles; sel_last only at 15; done pulses 1 cycle later.
- Stalls:
  - Stimulus: in_valid toggled 1/0 and sel_ready low for 3 cycles at select=5.
  - Response: all 16 bytes packed in order; select holds 5 for 3 cycles; no index is skipped or repeated.
- Ignored start:
  - Stimulus: pulse start during LOAD (after 4 bytes) and again during SCAN.
  - Response: no change to the byte counter, buffer, select or state.
- Mid-frame reset:
  - Stimulus: rst after 7 bytes loaded.
  - Response: next cycle IDLE with buffer 0; a new start plus 16 bytes yields a correct frame and exactly one done.
- MMD_REVERSE_SCAN_EN defined:
  - Stimulus: the same full frame.
  - Response: select sequence 15..0; sel_last at 0; buffer identical to the ascending build.
